// File: rtl/rv_pkg.sv
// Shared types and Wishbone field widths for the rv core bus fabric.
package rv_pkg;
  localparam int ADR_W = 30;
  localparam int SEL_W = 4;
  localparam int DAT_W = 32;

  localparam logic [15:0] LOCAL_PREFIX_DEF = 16'hFFFF;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {EXT, LOC} ssel_t;
endpackage

// File: rtl/rv_wb_watchdog.sv
// Stall counter for a granted Wishbone cycle; flags expiry at TIMEOUT cycles.
module rv_wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr,
  input  logic inc,
  output logic expire_o
);
  logic [15:0] cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                      cnt <= '0;
    else if (clr)                      cnt <= '0;
    else if (inc && cnt != 16'hFFFF)   cnt <= cnt + 16'd1;
  end

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire_o = 1'b0;
    end else begin : g_on
      assign expire_o = (cnt == 16'(TIMEOUT));
    end
  endgenerate
endmodule

// File: rtl/rv_wb_arbiter.sv
// Two-master / two-slave Wishbone classic arbiter with round-robin grant,
// address-prefix slave routing and a hung-cycle watchdog.
module rv_wb_arbiter
  import rv_pkg::*;
#(
  parameter logic [15:0] LOCAL_PREFIX    = LOCAL_PREFIX_DEF,
  parameter bit          ENABLE_LOCALMAP = 1'b1,
  parameter int          TIMEOUT         = 255
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic [DAT_W-1:0] m0_dat_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             ext_cyc_o,
  output logic             ext_stb_o,
  output logic             ext_we_o,
  output logic [SEL_W-1:0] ext_sel_o,
  output logic [ADR_W-1:0] ext_adr_o,
  output logic [DAT_W-1:0] ext_dat_o,
  input  logic             ext_ack_i,
  input  logic [DAT_W-1:0] ext_dat_i,
  output logic             loc_cyc_o,
  output logic             loc_stb_o,
  output logic             loc_we_o,
  output logic [SEL_W-1:0] loc_sel_o,
  output logic [ADR_W-1:0] loc_adr_o,
  output logic [DAT_W-1:0] loc_dat_o,
  input  logic             loc_ack_i,
  input  logic [DAT_W-1:0] loc_dat_i,
  output logic             timeout_o
);
  state_t state, state_nxt;
  ssel_t  ssel, ssel_nxt;
  logic   gnt, gnt_nxt, last, last_nxt;

  logic             g_cyc, g_stb, g_we;
  logic [SEL_W-1:0] g_sel;
  logic [ADR_W-1:0] g_adr;
  logic [DAT_W-1:0] g_dat;
  logic             s_ack;
  logic [DAT_W-1:0] s_dat;
  logic             busy, expire, fire, ack_ok, drive;
  logic             win;
  logic [ADR_W-1:0] win_adr;

  always_comb begin
    g_cyc = gnt ? m1_cyc_i : m0_cyc_i;
    g_stb = gnt ? m1_stb_i : m0_stb_i;
    g_we  = gnt ? m1_we_i  : m0_we_i;
    g_sel = gnt ? m1_sel_i : m0_sel_i;
    g_adr = gnt ? m1_adr_i : m0_adr_i;
    g_dat = gnt ? m1_dat_i : m0_dat_i;
  end

  assign s_ack = (ssel == LOC) ? loc_ack_i : ext_ack_i;
  assign s_dat = (ssel == LOC) ? loc_dat_i : ext_dat_i;

  assign busy   = (state == BUSY);
  // A slave ack in the expiry cycle wins; a dropped cyc ignores late acks.
  assign ack_ok = busy && g_cyc && s_ack;
  assign fire   = busy && g_cyc && expire && !s_ack;
  assign drive  = busy && g_cyc && !fire;

  rv_wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr      (!busy || s_ack),
    .inc      (busy && g_stb && !s_ack),
    .expire_o (expire)
  );

  // Tie goes to the master that was not served last.
  assign win     = (m0_cyc_i && m1_cyc_i) ? !last : m1_cyc_i;
  assign win_adr = win ? m1_adr_i : m0_adr_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
      ssel  <= EXT;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
      ssel  <= ssel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    ssel_nxt  = ssel;
    case (state)
      IDLE: begin
        if (m0_cyc_i || m1_cyc_i) begin
          state_nxt = BUSY;
          gnt_nxt   = win;
          last_nxt  = win;
          ssel_nxt  = (ENABLE_LOCALMAP && win_adr[ADR_W-1:ADR_W-16] == LOCAL_PREFIX)
                      ? LOC : EXT;
        end
      end
      BUSY: begin
        if (!g_cyc || fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ext_cyc_o = 1'b0; ext_stb_o = 1'b0; ext_we_o = 1'b0;
    ext_sel_o = '0;   ext_adr_o = '0;   ext_dat_o = '0;
    loc_cyc_o = 1'b0; loc_stb_o = 1'b0; loc_we_o = 1'b0;
    loc_sel_o = '0;   loc_adr_o = '0;   loc_dat_o = '0;
    if (busy && ssel == LOC) begin
      loc_cyc_o = drive;
      loc_stb_o = drive && g_stb;
      loc_we_o  = g_we;
      loc_sel_o = g_sel;
      loc_adr_o = g_adr;
      loc_dat_o = g_dat;
    end else if (busy) begin
      ext_cyc_o = drive;
      ext_stb_o = drive && g_stb;
      ext_we_o  = g_we;
      ext_sel_o = g_sel;
      ext_adr_o = g_adr;
      ext_dat_o = g_dat;
    end
  end

  always_comb begin
    m0_ack_o = 1'b0; m0_err_o = 1'b0; m0_dat_o = '0;
    m1_ack_o = 1'b0; m1_err_o = 1'b0; m1_dat_o = '0;
    if (gnt) begin
      m1_ack_o = ack_ok || fire;
      m1_err_o = fire;
      m1_dat_o = drive ? s_dat : '0;
    end else begin
      m0_ack_o = ack_ok || fire;
      m0_err_o = fire;
      m0_dat_o = drive ? s_dat : '0;
    end
  end

  assign timeout_o = fire;
endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Randomized bench for rv_wb_arbiter checked against a transaction-level model.
module tb_rv_wb_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0/1 = master 0/1; slave index 0 = ext, 1 = loc
  logic [1:0]  m_cyc, m_stb, m_we, m_ack, m_err;
  logic [3:0]  m_sel  [2];
  logic [29:0] m_adr  [2];
  logic [31:0] m_wdat [2];
  logic [31:0] m_rdat [2];
  logic [1:0]  s_cyc, s_stb, s_we, s_ack;
  logic [3:0]  s_sel  [2];
  logic [29:0] s_adr  [2];
  logic [31:0] s_wdat [2];
  logic [31:0] s_rdat [2];
  logic        timeout;

  logic        n_cyc, n_stb, n_we, n_ack, n_err, n0_ack, n0_err, n_to;
  logic [3:0]  n_sel, n_esel, n_lsel;
  logic [29:0] n_adr, n_eadr, n_ladr;
  logic [31:0] n_wdat, n_rdat, n0_rdat, n_ewdat, n_lwdat, n_erdat;
  logic        n_ecyc, n_estb, n_ewe, n_eack, n_lcyc, n_lstb, n_lwe;

  int  total_cnt = 0;
  int  pass_cnt  = 0;
  bit  last_m;

  rv_wb_arbiter #(.LOCAL_PREFIX(16'hFFFF), .ENABLE_LOCALMAP(1'b1), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_wdat[0]),
    .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]), .m0_dat_o(m_rdat[0]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_wdat[1]),
    .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]), .m1_dat_o(m_rdat[1]),
    .ext_cyc_o(s_cyc[0]), .ext_stb_o(s_stb[0]), .ext_we_o(s_we[0]), .ext_sel_o(s_sel[0]),
    .ext_adr_o(s_adr[0]), .ext_dat_o(s_wdat[0]), .ext_ack_i(s_ack[0]), .ext_dat_i(s_rdat[0]),
    .loc_cyc_o(s_cyc[1]), .loc_stb_o(s_stb[1]), .loc_we_o(s_we[1]), .loc_sel_o(s_sel[1]),
    .loc_adr_o(s_adr[1]), .loc_dat_o(s_wdat[1]), .loc_ack_i(s_ack[1]), .loc_dat_i(s_rdat[1]),
    .timeout_o(timeout)
  );

  rv_wb_arbiter #(.LOCAL_PREFIX(16'hFFFF), .ENABLE_LOCALMAP(1'b0), .TIMEOUT(0)) dut_nomap (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_cyc_i(1'b0), .m0_stb_i(1'b0), .m0_we_i(1'b0), .m0_sel_i(4'h0),
    .m0_adr_i(30'h0), .m0_dat_i(32'h0),
    .m0_ack_o(n0_ack), .m0_err_o(n0_err), .m0_dat_o(n0_rdat),
    .m1_cyc_i(n_cyc), .m1_stb_i(n_stb), .m1_we_i(n_we), .m1_sel_i(n_sel),
    .m1_adr_i(n_adr), .m1_dat_i(n_wdat),
    .m1_ack_o(n_ack), .m1_err_o(n_err), .m1_dat_o(n_rdat),
    .ext_cyc_o(n_ecyc), .ext_stb_o(n_estb), .ext_we_o(n_ewe), .ext_sel_o(n_esel),
    .ext_adr_o(n_eadr), .ext_dat_o(n_ewdat), .ext_ack_i(n_eack), .ext_dat_i(n_erdat),
    .loc_cyc_o(n_lcyc), .loc_stb_o(n_lstb), .loc_we_o(n_lwe), .loc_sel_o(n_lsel),
    .loc_adr_o(n_ladr), .loc_dat_o(n_lwdat), .loc_ack_i(1'b0), .loc_dat_i(32'h0),
    .timeout_o(n_to)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk);
    total_cnt++;
    if ({s_cyc, s_stb, m_ack, m_err, timeout} !== 9'b0)
      $display("FAIL quiet_%s got=%b want=0", tag, {s_cyc, s_stb, m_ack, m_err, timeout});
    else pass_cnt++;
    step();
  endtask

  task automatic rand_req(input int m);
    logic [29:0] a;
    a = 30'($urandom);
    if ($urandom_range(0, 1) == 1) a[29:14] = 16'hFFFF;
    else if (a[29:14] == 16'hFFFF) a[29] = 1'b0;
    m_adr[m] = a; m_we[m] = 1'($urandom); m_sel[m] = 4'($urandom);
    m_wdat[m] = $urandom; m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
  endtask

  // Runs the granted master's beats; the slave acks d cycles after stb is seen.
  task automatic serve(input int m, input int beats, input int fixed_d,
                       input bit use_rd, input logic [31:0] fixed_rd, output bit to);
    int sl, o, d;
    bit f, ok, acked;
    logic [31:0] rd;
    sl = (m_adr[m][29:14] == 16'hFFFF) ? 1 : 0;
    o  = 1 - m;
    to = 1'b0;
    f  = 1'b0;
    for (int b = 0; b < beats; b++) begin
      d = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 6));
      acked = 1'b0;
      for (int k = 0; k <= 10 && !acked; k++) begin
        rd = use_rd ? fixed_rd : $urandom;
        s_ack[sl] = (k == d); s_rdat[sl] = rd;
        s_ack[1-sl] = 1'($urandom); s_rdat[1-sl] = $urandom;
        f  = (k == TO) && (d > TO);
        ok = (k == d) && (d <= TO);
        @(negedge clk);
        total_cnt++;
        if ({s_cyc[sl], s_stb[sl], s_adr[sl], s_sel[sl], s_we[sl], s_wdat[sl]} !==
            {!f, !f, m_adr[m], m_sel[m], m_we[m], m_wdat[m]})
          $display("FAIL route m%0d slv%0d k=%0d got=%b%b_%h_%h_%b_%h want=%b%b_%h_%h_%b_%h",
                   m, sl, k, s_cyc[sl], s_stb[sl], s_adr[sl], s_sel[sl], s_we[sl], s_wdat[sl],
                   !f, !f, m_adr[m], m_sel[m], m_we[m], m_wdat[m]);
        else pass_cnt++;
        total_cnt++;
        if ({s_cyc[1-sl], s_stb[1-sl], s_we[1-sl], s_sel[1-sl], s_adr[1-sl], s_wdat[1-sl]} !== 69'b0)
          $display("FAIL idle_slave slv%0d k=%0d got cyc=%b adr=%h want zeros",
                   1 - sl, k, s_cyc[1-sl], s_adr[1-sl]);
        else pass_cnt++;
        total_cnt++;
        if ({m_ack[m], m_err[m], timeout, (ok || f) ? m_rdat[m] : 32'h0} !==
            {ok || f, f, f, ok ? rd : 32'h0})
          $display("FAIL resp m%0d k=%0d d=%0d got ack=%b err=%b to=%b dat=%h want ack=%b err=%b to=%b dat=%h",
                   m, k, d, m_ack[m], m_err[m], timeout, m_rdat[m], ok || f, f, f, ok ? rd : 32'h0);
        else pass_cnt++;
        total_cnt++;
        if ({m_ack[o], m_err[o], m_rdat[o]} !== 34'b0)
          $display("FAIL other_master m%0d got ack=%b err=%b dat=%h want 0", o, m_ack[o], m_err[o], m_rdat[o]);
        else pass_cnt++;
        step();
        acked = ok || f;
      end
      if (!acked) begin
        total_cnt++;
        $display("FAIL serve_bound m%0d got no ack want ack within bound", m);
      end
      if (f) begin
        to = 1'b1;
        break;
      end
      if (b < beats - 1) begin
        m_we[m] = 1'($urandom); m_sel[m] = 4'($urandom); m_wdat[m] = $urandom;
      end
    end
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; s_ack = 2'b00;
  endtask

  // Requests in 'mask' are already driven and the arbiter is idle this cycle.
  task automatic run_iter(input bit [1:0] mask, input int fixed_d, input int nbeats,
                          input bit use_rd, input logic [31:0] rd);
    int first, m, pre, nb;
    bit to;
    first = (mask == 2'b11) ? int'(!last_m) : (mask[1] ? 1 : 0);
    pre = 1;
    for (int i = 0; i < ((mask == 2'b11) ? 2 : 1); i++) begin
      m = (i == 0) ? first : 1 - first;
      repeat (pre) check_quiet("arb");
      last_m = m[0];
      nb = (nbeats > 0) ? nbeats : int'($urandom_range(1, 2));
      serve(m, nb, fixed_d, use_rd, rd, to);
      pre = to ? 1 : 2;
    end
    check_quiet("release");
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b11; s_ack = 2'b11;
    m_adr[0] = 30'h1234; m_adr[1] = 30'h3FFFC000;
    repeat (3) begin
      @(negedge clk);
      total_cnt++;
      if ({s_cyc, s_stb, s_we, m_ack, m_err, timeout, s_adr[0], s_adr[1], m_rdat[0], m_rdat[1]} !== 135'b0)
        $display("FAIL reset_outputs got cyc=%b stb=%b we=%b ack=%b err=%b to=%b want 0",
                 s_cyc, s_stb, s_we, m_ack, m_err, timeout);
      else pass_cnt++;
    end
    m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00; s_ack = 2'b00;
    rst_n = 1'b1;
    last_m = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    m_adr[1] = 30'h0000_0400; m_we[1] = 1'b0; m_sel[1] = 4'hF; m_wdat[1] = 32'h0;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    run_iter(2'b10, 2, 1, 1'b1, 32'hCAFEF00D);
  endtask

  task automatic test_local_routing();
    m_adr[1] = 30'h3FFF_C004; m_we[1] = 1'b1; m_sel[1] = 4'b0100; m_wdat[1] = $urandom;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    run_iter(2'b10, 1, 1, 1'b0, 32'h0);
    n_adr = 30'h3FFF_C004; n_we = 1'b1; n_sel = 4'b0100; n_wdat = $urandom;
    n_cyc = 1'b1; n_stb = 1'b1; n_erdat = 32'h1234_5678;
    @(negedge clk);
    total_cnt++;
    if ({n_ecyc, n_lcyc} !== 2'b00) $display("FAIL nomap_arb got ecyc=%b lcyc=%b want 00", n_ecyc, n_lcyc);
    else pass_cnt++;
    step();
    n_eack = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({n_ecyc, n_estb, n_ewe, n_esel, n_eadr, n_ewdat, n_lcyc, n_lstb} !==
        {1'b1, 1'b1, 1'b1, 4'b0100, 30'h3FFF_C004, n_wdat, 1'b0, 1'b0})
      $display("FAIL nomap_route got ecyc=%b esel=%b eadr=%h lcyc=%b want ecyc=1 esel=0100 eadr=3fffc004 lcyc=0",
               n_ecyc, n_esel, n_eadr, n_lcyc);
    else pass_cnt++;
    total_cnt++;
    if ({n_ack, n_err, n_rdat} !== {1'b1, 1'b0, 32'h1234_5678})
      $display("FAIL nomap_ack got ack=%b err=%b dat=%h want ack=1 err=0 dat=12345678", n_ack, n_err, n_rdat);
    else pass_cnt++;
    step();
    n_cyc = 1'b0; n_stb = 1'b0; n_eack = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    test_reset();
    repeat (2) begin
      rand_req(0); rand_req(1);
      m_adr[1][0] = ~m_adr[0][0];
      run_iter(2'b11, -1, 1, 1'b0, 32'h0);
    end
  endtask

  task automatic test_watchdog();
    m_adr[0] = 30'h0000_0100; m_we[0] = 1'b0; m_sel[0] = 4'hF; m_wdat[0] = 32'h0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    run_iter(2'b01, 6, 1, 1'b0, 32'h0);
    rand_req(0); rand_req(1);
    run_iter(2'b11, 6, 2, 1'b0, 32'h0);
    rand_req(0);
    run_iter(2'b01, TO, 1, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid();
    m_adr[0] = 30'h0000_0200; m_we[0] = 1'b0; m_sel[0] = 4'hF;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    check_quiet("mid_arb");
    #2;
    total_cnt++;
    if ({s_cyc[0], s_stb[0]} !== 2'b11) $display("FAIL mid_busy got cyc/stb=%b%b want 11", s_cyc[0], s_stb[0]);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({s_cyc, s_stb, m_ack, m_err, timeout} !== 9'b0)
      $display("FAIL mid_reset_drop got cyc=%b stb=%b ack=%b want 0", s_cyc, s_stb, m_ack);
    else pass_cnt++;
    m_cyc = 2'b00; m_stb = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    last_m = 1'b1;
    step();
    rand_req(0); rand_req(1);
    m_adr[1][0] = ~m_adr[0][0];
    run_iter(2'b11, -1, 1, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    bit [1:0] mask;
    for (int it = 0; it < 40; it++) begin
      mask = 2'($urandom_range(1, 3));
      if (mask[0]) rand_req(0);
      if (mask[1]) rand_req(1);
      run_iter(mask, -1, 0, 1'b0, 32'h0);
      repeat ($urandom_range(0, 2)) check_quiet("gap");
    end
  endtask

  initial begin
    m_cyc = '0; m_stb = '0; m_we = '0; s_ack = '0;
    for (int i = 0; i < 2; i++) begin
      m_sel[i] = '0; m_adr[i] = '0; m_wdat[i] = '0; s_rdat[i] = '0;
    end
    n_cyc = 1'b0; n_stb = 1'b0; n_we = 1'b0; n_sel = '0; n_adr = '0; n_wdat = '0;
    n_eack = 1'b0; n_erdat = '0;
    last_m = 1'b1;
    test_reset();
    test_single_read();
    test_local_routing();
    test_simultaneous();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/rv_wb_arbiter.md
# rv_wb_arbiter

Two-master, two-slave Wishbone classic arbiter that shares the core's memory interface between the instruction fetch port (master 0) and `rv_dbus` (master 1). It routes each granted cycle to either the external system bus or the processor-local bus, based on address prefix. It also terminates hung cycles with a watchdog. It sits between the core front end / `rv_dbus` and the SoC interconnect.

## Interface
- `LOCAL_PREFIX`, 16'hFFFF: `adr[31:16]` value that selects the local slave.
- `ENABLE_LOCALMAP`, 1: 0 routes every cycle to the external slave.
- `TIMEOUT`, 255: cycles of `stb` without `ack` before a forced termination; 0 disables the watchdog; maximum 65535.
- `clk_i` in 1: single clock, rising edge.
- `rst_n_i` in 1: reset, asynchronous and active-low.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: instruction master control.
- `m0_sel_i` in 4; `m0_adr_i` in 30 `[31:2]`; `m0_dat_i` in 32: instruction master request.
- `m0_ack_o`, `m0_err_o` out 1 each; `m0_dat_o` out 32: instruction master response.
- `m1_*`: identical port set for the data master (`rv_dbus`).
- `ext_cyc_o`, `ext_stb_o`, `ext_we_o` out 1; `ext_sel_o` out 4; `ext_adr_o` out 30; `ext_dat_o` out 32: external slave request.
- `ext_ack_i` in 1; `ext_dat_i` in 32: external slave response.
- `loc_*`: identical port set for the local slave.
- `timeout_o` out 1: one-cycle pulse when the watchdog fires.

## Operation
- States: `IDLE`, `BUSY`. The grant register `gnt` (0/1), the slave select `ssel` (`EXT`/`LOC`) and the round-robin pointer `last` are all registered.
- **`IDLE`**
  - If any `mX_cyc_i` is high, choose a winner and go to `BUSY`.
  - Single requester: it wins.
  - Both requesters: the master not equal to `last` wins.
  - Latch `gnt`. Set `last` to the winner.
  - Latch `ssel` = `LOC` when `ENABLE_LOCALMAP` and the winner's `adr[31:16] == LOCAL_PREFIX`; otherwise `EXT`.
- **`BUSY`**
  - The selected slave's request outputs equal the granted master's inputs combinationally.
  - The granted master's `ack_o`/`dat_o` equal the selected slave's `ack_i`/`dat_i`.
  - The non-selected slave sees all zeros. The non-granted master sees `ack=0`, `err=0`, `dat=0`.
  - Grant is held for the whole cycle, including multi-beat runs, for as long as the granted master holds `cyc`.
  - When the granted `cyc` drops, go to `IDLE`. `ssel` is never re-evaluated mid-grant.
- **Watchdog**
  - The 16-bit counter clears in `IDLE` and on every slave ack.
  - It increments in `BUSY` while granted `stb=1` and `ack=0`.
  - When the count reaches `TIMEOUT`, for one cycle:
    - the granted master gets `ack=1`, `err=1`, `dat=0`;
    - slave `cyc`/`stb` are forced low;
    - `timeout_o=1`.
  - The state then returns to `IDLE` regardless of master `cyc`.
  - `rv_dbus` ignores `err`, so the ack releases it.
- **Boundaries**
  - A slave ack arriving in the same cycle the watchdog fires counts as a normal ack: `err=0`, no `timeout_o`.
  - A master dropping `cyc` while its ack is pending: the slave is released that same cycle, and a late ack is ignored.
  - A request from the non-granted master waits. Master `cyc` held continuously keeps the grant; fairness applies per cycle boundary.

## Timing
- Reset values: state `IDLE`, `gnt=0`, `last=1` (so m0 wins the first tie), `ssel=EXT`, counter 0. All outputs are 0 during reset.
- Reset mid-cycle: slave `cyc`/`stb` drop asynchronously; no ack is produced.
- Arbitration latency: `cyc` rises in cycle N, and slave `cyc`/`stb` rise in N+1.
- Slave ack to master ack: 0 cycles (combinational).
- Back-to-back grants need one `IDLE` cycle between them.
- Watchdog: with `stb` first visible to the slave in cycle N and no ack, `err`/`ack` assert in cycle N+`TIMEOUT`.

## Structure
- Shared package `rv_pkg`:
  - state enum (`IDLE`, `BUSY`);
  - slave-select enum (`EXT`, `LOC`);
  - default `LOCAL_PREFIX`;
  - Wishbone field widths (`ADR_W=30`, `SEL_W=4`, `DAT_W=32`).
- Sub-module `rv_wb_watchdog`: 16-bit counter with `clr`, `inc`, `TIMEOUT` parameter and `expire_o`; `TIMEOUT=0` ties `expire_o` low.
- All muxing lives in the top level.

## Test plan
- **Single read:** m1 read `adr=30'h0000_0400`, ext acks 2 cycles later with `dat_i=32'hCAFEF00D` → `ext_cyc_o` rises 1 cycle after `m1_cyc_i`; `m1_ack_o` and `m1_dat_o=32'hCAFEF00D` arrive in the same cycle as `ext_ack_i`.
- **Local routing:** m1 write to `0xFFFF0010` with `sel=4'b0100` → only `loc_*` active, `loc_sel_o=4'b0100`, `ext_cyc_o=0`; with `ENABLE_LOCALMAP=0` the same access goes to ext.
- **Simultaneous requests:** both `cyc` rise together after reset → m0 granted first, then m1. Repeating the simultaneous rise → m0 again, because `last=1`.
- **Watchdog:** `TIMEOUT=4`, ext never acks → `m0_ack_o=1`, `m0_err_o=1`, `m0_dat_o=0`, `timeout_o=1` for exactly one cycle, 4 cycles after `ext_stb_o` rises, and `ext_cyc_o` is low in that same cycle. A coincident-ack variant → `err=0`, no `timeout_o`.
- **Reset mid-operation:** pull `rst_n_i` low during a `BUSY` cycle, off a clock edge → `ext_cyc_o`/`ext_stb_o` drop immediately. After release, an m0/m1 tie is won by m0.
